// File: rtl/retire_rob_if.sv
// Rename/execute-facing bundle of the retirement buffer: allocation, completion,
// retirement/RRAT update and free-list return.
interface retire_rob_if #(
  parameter int TAGW = 4
);
  logic            flush;
  logic            alloc_valid;
  logic [4:0]      alloc_arch_reg;
  logic [5:0]      alloc_new_phys;
  logic [5:0]      alloc_old_phys;
  logic            alloc_reg_write;
  logic [31:0]     alloc_pc;
  logic [TAGW-1:0] alloc_tag;
  logic            rob_halt;
  logic            cmpl_valid;
  logic [TAGW-1:0] cmpl_tag;
  logic            retire_valid;
  logic [4:0]      retire_arch_reg;
  logic [5:0]      retire_new_phys;
  logic [31:0]     retire_pc;
  logic            rrat_free;
  logic [5:0]      rrat_free_reg;
  logic            empty;
  logic [31:0]     retired_count;

  modport master (
    output flush, alloc_valid, alloc_arch_reg, alloc_new_phys, alloc_old_phys,
           alloc_reg_write, alloc_pc, cmpl_valid, cmpl_tag,
    input  alloc_tag, rob_halt, retire_valid, retire_arch_reg, retire_new_phys,
           retire_pc, rrat_free, rrat_free_reg, empty, retired_count
  );

  modport slave (
    input  flush, alloc_valid, alloc_arch_reg, alloc_new_phys, alloc_old_phys,
           alloc_reg_write, alloc_pc, cmpl_valid, cmpl_tag,
    output alloc_tag, rob_halt, retire_valid, retire_arch_reg, retire_new_phys,
           retire_pc, rrat_free, rrat_free_reg, empty, retired_count
  );
endinterface

// File: rtl/retire_rob.sv
// In-order retirement buffer: allocates from Rename, collects out-of-order
// completions, retires the oldest done entry per cycle into the RRAT/free list.
module retire_rob #(
  parameter int DEPTH = 16,  // power of two, >= 2
  parameter int TAGW  = 4    // log2(DEPTH)
) (
  input  logic      CLK,
  input  logic      RESET,
  retire_rob_if.slave rob
);

  typedef struct packed {
    logic [4:0]  arch;
    logic [5:0]  new_phys;
    logic [5:0]  old_phys;
    logic        reg_write;
    logic [31:0] pc;
  } entry_t;

  entry_t            payload_q [DEPTH];
  entry_t            alloc_entry;
  entry_t            head_entry;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  done_q, done_d;
  logic [TAGW-1:0]   head_q, head_d;
  logic [TAGW-1:0]   tail_q, tail_d;
  logic [TAGW:0]     count_q, count_d;

  logic              retire_valid_q, retire_valid_d;
  logic [4:0]        retire_arch_reg_q, retire_arch_reg_d;
  logic [5:0]        retire_new_phys_q, retire_new_phys_d;
  logic [31:0]       retire_pc_q, retire_pc_d;
  logic              rrat_free_q, rrat_free_d;
  logic [5:0]        rrat_free_reg_q, rrat_free_reg_d;
  logic [31:0]       retired_count_q, retired_count_d;

  logic              full;
  logic              is_empty;
  logic              do_alloc;
  logic              do_retire;
  logic              cmpl_hit;

  assign alloc_entry = '{arch:      rob.alloc_arch_reg,
                         new_phys:  rob.alloc_new_phys,
                         old_phys:  rob.alloc_old_phys,
                         reg_write: rob.alloc_reg_write,
                         pc:        rob.alloc_pc};
  assign head_entry  = payload_q[head_q];

  // Full/empty come from the current count only, so a retire never unblocks
  // an allocation on the same edge.
  assign full      = (count_q == (TAGW+1)'(DEPTH));
  assign is_empty  = (count_q == '0);
  assign do_alloc  = rob.alloc_valid && !full;
  assign do_retire = valid_q[head_q] && done_q[head_q];
  // The tail slot is never valid while an allocation is accepted, but the
  // explicit guard keeps a same-cycle completion from marking the new entry.
  assign cmpl_hit  = rob.cmpl_valid && valid_q[rob.cmpl_tag] &&
                     !(do_alloc && (rob.cmpl_tag == tail_q));

  assign rob.alloc_tag       = tail_q;
  assign rob.rob_halt        = full;
  assign rob.empty           = is_empty;
  assign rob.retire_valid    = retire_valid_q;
  assign rob.retire_arch_reg = retire_arch_reg_q;
  assign rob.retire_new_phys = retire_new_phys_q;
  assign rob.retire_pc       = retire_pc_q;
  assign rob.rrat_free       = rrat_free_q;
  assign rob.rrat_free_reg   = rrat_free_reg_q;
  assign rob.retired_count   = retired_count_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    valid_d           = valid_q;
    done_d            = done_q;
    head_d            = head_q;
    tail_d            = tail_q;
    count_d           = count_q;
    retire_valid_d    = 1'b0;
    rrat_free_d       = 1'b0;
    retire_arch_reg_d = retire_arch_reg_q;
    retire_new_phys_d = retire_new_phys_q;
    retire_pc_d       = retire_pc_q;
    rrat_free_reg_d   = rrat_free_reg_q;
    retired_count_d   = retired_count_q;

    if (rob.flush) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Completion first, so a retire clearing the head slot wins over it.
      if (cmpl_hit) begin
        done_d[rob.cmpl_tag] = 1'b1;
      end

      if (do_retire) begin
        valid_d[head_q]   = 1'b0;
        done_d[head_q]    = 1'b0;
        head_d            = head_q + TAGW'(1);
        retire_valid_d    = 1'b1;
        retire_arch_reg_d = head_entry.arch;
        retire_new_phys_d = head_entry.new_phys;
        retire_pc_d       = head_entry.pc;
        rrat_free_d       = head_entry.reg_write && (head_entry.arch != 5'd0);
        rrat_free_reg_d   = head_entry.old_phys;
        retired_count_d   = retired_count_q + 32'd1;
      end

      if (do_alloc) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
        tail_d          = tail_q + TAGW'(1);
      end

      count_d = count_q + (TAGW+1)'(do_alloc) - (TAGW+1)'(do_retire);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid_q           <= '0;
      done_q            <= '0;
      head_q            <= '0;
      tail_q            <= '0;
      count_q           <= '0;
      retire_valid_q    <= 1'b0;
      retire_arch_reg_q <= '0;
      retire_new_phys_q <= '0;
      retire_pc_q       <= '0;
      rrat_free_q       <= 1'b0;
      rrat_free_reg_q   <= '0;
      retired_count_q   <= '0;
    end else begin
      valid_q           <= valid_d;
      done_q            <= done_d;
      head_q            <= head_d;
      tail_q            <= tail_d;
      count_q           <= count_d;
      retire_valid_q    <= retire_valid_d;
      retire_arch_reg_q <= retire_arch_reg_d;
      retire_new_phys_q <= retire_new_phys_d;
      retire_pc_q       <= retire_pc_d;
      rrat_free_q       <= rrat_free_d;
      rrat_free_reg_q   <= rrat_free_reg_d;
      retired_count_q   <= retired_count_d;
    end
  end

  // NOTE: payload storage is not reset; valid_q gates every read, so stale data is never used.
  always_ff @(posedge CLK) begin
    if (do_alloc && !rob.flush) begin
      payload_q[tail_q] <= alloc_entry;
    end
  end

endmodule

// File: tb/tb_retire_rob.sv
// Directed bench for retire_rob: a cycle-by-cycle vector table for the basic
// retire flow, then hand-written sequences for full, flush, stray completion and reset.
module tb_retire_rob;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  retire_rob_if #(.TAGW(4)) rob_bus ();

  retire_rob #(.DEPTH(16), .TAGW(4)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .rob   (rob_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        a_v;
    logic [4:0]  a_arch;
    logic [5:0]  a_new;
    logic [5:0]  a_old;
    logic        a_rw;
    logic [31:0] a_pc;
    logic        c_v;
    logic [3:0]  c_tag;
    logic        e_rv;
    logic        e_rf;
    logic [31:0] e_pc;
    logic [4:0]  e_arch;
    logic [5:0]  e_new;
    logic [5:0]  e_free;
    logic [31:0] e_cnt;
    logic        e_empty;
    logic [3:0]  e_tag;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t mk(int av, int arch, int np, int op, int rw, int pc,
                              int cv, int ct, int rv, int rf, int epc, int earch,
                              int enew, int efree, int ecnt, int eempty, int etag);
    vec_t v;
    v.a_v     = av[0];
    v.a_arch  = arch[4:0];
    v.a_new   = np[5:0];
    v.a_old   = op[5:0];
    v.a_rw    = rw[0];
    v.a_pc    = pc;
    v.c_v     = cv[0];
    v.c_tag   = ct[3:0];
    v.e_rv    = rv[0];
    v.e_rf    = rf[0];
    v.e_pc    = epc;
    v.e_arch  = earch[4:0];
    v.e_new   = enew[5:0];
    v.e_free  = efree[5:0];
    v.e_cnt   = ecnt;
    v.e_empty = eempty[0];
    v.e_tag   = etag[3:0];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rob_bus.flush           = 1'b0;
    rob_bus.alloc_valid     = 1'b0;
    rob_bus.alloc_arch_reg  = '0;
    rob_bus.alloc_new_phys  = '0;
    rob_bus.alloc_old_phys  = '0;
    rob_bus.alloc_reg_write = 1'b0;
    rob_bus.alloc_pc        = '0;
    rob_bus.cmpl_valid      = 1'b0;
    rob_bus.cmpl_tag        = '0;
  endtask

  task automatic alloc(input int arch, input int np, input int op, input int rw, input int pc);
    rob_bus.alloc_valid     = 1'b1;
    rob_bus.alloc_arch_reg  = arch[4:0];
    rob_bus.alloc_new_phys  = np[5:0];
    rob_bus.alloc_old_phys  = op[5:0];
    rob_bus.alloc_reg_write = rw[0];
    rob_bus.alloc_pc        = pc;
    step();
    rob_bus.alloc_valid     = 1'b0;
  endtask

  task automatic cmpl(input int tag);
    rob_bus.cmpl_valid = 1'b1;
    rob_bus.cmpl_tag   = tag[3:0];
    step();
    rob_bus.cmpl_valid = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    idle();

    // inputs: av arch new old rw pc cv ctag | expected: rv rf pc arch new free cnt empty tag
    vecs[0]  = mk(1, 5, 33, 5, 1, 'h100, 0, 0,  0, 0, 0,     0, 0,  0,  0, 0, 1);
    vecs[1]  = mk(1, 6, 34, 6, 1, 'h104, 0, 0,  0, 0, 0,     0, 0,  0,  0, 0, 2);
    vecs[2]  = mk(1, 7, 35, 7, 1, 'h108, 0, 0,  0, 0, 0,     0, 0,  0,  0, 0, 3);
    vecs[3]  = mk(0, 0, 0,  0, 0, 0,     1, 2,  0, 0, 0,     0, 0,  0,  0, 0, 3);
    vecs[4]  = mk(0, 0, 0,  0, 0, 0,     1, 1,  0, 0, 0,     0, 0,  0,  0, 0, 3);
    vecs[5]  = mk(0, 0, 0,  0, 0, 0,     1, 0,  0, 0, 0,     0, 0,  0,  0, 0, 3);
    vecs[6]  = mk(0, 0, 0,  0, 0, 0,     0, 0,  1, 1, 'h100, 5, 33, 5,  1, 0, 3);
    vecs[7]  = mk(0, 0, 0,  0, 0, 0,     0, 0,  1, 1, 'h104, 6, 34, 6,  2, 0, 3);
    vecs[8]  = mk(0, 0, 0,  0, 0, 0,     0, 0,  1, 1, 'h108, 7, 35, 7,  3, 1, 3);
    vecs[9]  = mk(0, 0, 0,  0, 0, 0,     0, 0,  0, 0, 'h108, 7, 35, 7,  3, 1, 3);
    vecs[10] = mk(1, 3, 40, 20, 0, 'h200, 0, 0, 0, 0, 'h108, 7, 35, 7,  3, 0, 4);
    vecs[11] = mk(1, 0, 41, 21, 1, 'h204, 1, 3, 0, 0, 'h108, 7, 35, 7,  3, 0, 5);
    vecs[12] = mk(0, 0, 0,  0, 0, 0,     1, 4,  1, 0, 'h200, 3, 40, 20, 4, 0, 5);
    vecs[13] = mk(0, 0, 0,  0, 0, 0,     0, 0,  1, 0, 'h204, 0, 41, 21, 5, 1, 5);
    vecs[14] = mk(0, 0, 0,  0, 0, 0,     0, 0,  0, 0, 'h204, 0, 41, 21, 5, 1, 5);
    vecs[15] = mk(1, 8, 42, 22, 1, 'h208, 1, 5, 0, 0, 'h204, 0, 41, 21, 5, 0, 6);
    vecs[16] = mk(0, 0, 0,  0, 0, 0,     0, 0,  0, 0, 'h204, 0, 41, 21, 5, 0, 6);
    vecs[17] = mk(0, 0, 0,  0, 0, 0,     0, 0,  0, 0, 'h204, 0, 41, 21, 5, 0, 6);
    vecs[18] = mk(0, 0, 0,  0, 0, 0,     1, 5,  0, 0, 'h204, 0, 41, 21, 5, 0, 6);
    vecs[19] = mk(0, 0, 0,  0, 0, 0,     0, 0,  1, 1, 'h208, 8, 42, 22, 6, 1, 6);

    #12;
    check("reset retire_valid",  rob_bus.retire_valid, 0);
    check("reset rrat_free",     rob_bus.rrat_free, 0);
    check("reset retire_pc",     rob_bus.retire_pc, 0);
    check("reset rrat_free_reg", rob_bus.rrat_free_reg, 0);
    check("reset retired_count", rob_bus.retired_count, 0);
    check("reset empty",         rob_bus.empty, 1);
    check("reset rob_halt",      rob_bus.rob_halt, 0);
    check("reset alloc_tag",     rob_bus.alloc_tag, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      rob_bus.alloc_valid     = vecs[i].a_v;
      rob_bus.alloc_arch_reg  = vecs[i].a_arch;
      rob_bus.alloc_new_phys  = vecs[i].a_new;
      rob_bus.alloc_old_phys  = vecs[i].a_old;
      rob_bus.alloc_reg_write = vecs[i].a_rw;
      rob_bus.alloc_pc        = vecs[i].a_pc;
      rob_bus.cmpl_valid      = vecs[i].c_v;
      rob_bus.cmpl_tag        = vecs[i].c_tag;
      step();
      check($sformatf("v%0d retire_valid", i),    rob_bus.retire_valid,    vecs[i].e_rv);
      check($sformatf("v%0d rrat_free", i),       rob_bus.rrat_free,       vecs[i].e_rf);
      check($sformatf("v%0d retire_pc", i),       rob_bus.retire_pc,       vecs[i].e_pc);
      check($sformatf("v%0d retire_arch_reg", i), rob_bus.retire_arch_reg, vecs[i].e_arch);
      check($sformatf("v%0d retire_new_phys", i), rob_bus.retire_new_phys, vecs[i].e_new);
      check($sformatf("v%0d rrat_free_reg", i),   rob_bus.rrat_free_reg,   vecs[i].e_free);
      check($sformatf("v%0d retired_count", i),   rob_bus.retired_count,   vecs[i].e_cnt);
      check($sformatf("v%0d empty", i),           rob_bus.empty,           vecs[i].e_empty);
      check($sformatf("v%0d alloc_tag", i),       rob_bus.alloc_tag,       vecs[i].e_tag);
      check($sformatf("v%0d rob_halt", i),        rob_bus.rob_halt,        0);
    end
    idle();

    // Stray completion to tag 9 while empty (head = tail = 6, retired 6).
    cmpl(9);
    check("stray empty", rob_bus.empty, 1);
    check("stray retire_valid", rob_bus.retire_valid, 0);
    for (int i = 0; i < 10; i++) alloc(i + 1, i + 20, i + 40, 1, 'h2000 + 4 * i);
    for (int t = 6; t < 16; t++) if (t != 9) cmpl(t);
    repeat (3) step();
    check("stray blocked retired_count", rob_bus.retired_count, 9);
    check("stray blocked empty", rob_bus.empty, 0);
    check("stray blocked retire_valid", rob_bus.retire_valid, 0);
    check("stray blocked last pc", rob_bus.retire_pc, 'h2008);
    cmpl(9);
    step();
    check("tag9 retire_valid", rob_bus.retire_valid, 1);
    check("tag9 retire_pc", rob_bus.retire_pc, 'h200c);
    check("tag9 rrat_free_reg", rob_bus.rrat_free_reg, 43);
    check("tag9 retired_count", rob_bus.retired_count, 10);
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("drain%0d retire_valid", i), rob_bus.retire_valid, 1);
    end
    check("drain last pc", rob_bus.retire_pc, 'h2024);
    check("drain retired_count", rob_bus.retired_count, 16);
    check("drain empty", rob_bus.empty, 1);

    // Fill all 16 entries starting at tag 0.
    for (int i = 0; i < 16; i++) begin
      alloc(i + 1, 32 + i, i, 1, 'h1000 + 4 * i);
      if (i == 14) check("fill15 rob_halt", rob_bus.rob_halt, 0);
    end
    check("full rob_halt", rob_bus.rob_halt, 1);
    check("full alloc_tag", rob_bus.alloc_tag, 0);
    check("full empty", rob_bus.empty, 0);
    rob_bus.alloc_valid    = 1'b1;
    rob_bus.alloc_arch_reg = 5'd31;
    rob_bus.alloc_pc       = 32'hdead;
    step();
    check("17th rob_halt", rob_bus.rob_halt, 1);
    check("17th alloc_tag", rob_bus.alloc_tag, 0);
    rob_bus.alloc_pc   = 32'hbeef;
    rob_bus.cmpl_valid = 1'b1;
    rob_bus.cmpl_tag   = 4'd0;
    step();
    rob_bus.cmpl_valid = 1'b0;
    check("full cmpl retire_valid", rob_bus.retire_valid, 0);
    check("full cmpl rob_halt", rob_bus.rob_halt, 1);
    step();
    check("full retire retire_valid", rob_bus.retire_valid, 1);
    check("full retire pc", rob_bus.retire_pc, 'h1000);
    check("full retire arch", rob_bus.retire_arch_reg, 1);
    check("full retire rrat_free", rob_bus.rrat_free, 1);
    check("full retire free_reg", rob_bus.rrat_free_reg, 0);
    check("full retire retired_count", rob_bus.retired_count, 17);
    check("full retire rob_halt", rob_bus.rob_halt, 0);
    check("full retire alloc_tag", rob_bus.alloc_tag, 0);
    rob_bus.alloc_arch_reg = 5'd2;
    rob_bus.alloc_pc       = 32'h5000;
    step();
    rob_bus.alloc_valid = 1'b0;
    check("wrap alloc_tag", rob_bus.alloc_tag, 1);
    check("wrap rob_halt", rob_bus.rob_halt, 1);
    check("wrap retire_valid", rob_bus.retire_valid, 0);

    // Flush the full buffer.
    rob_bus.flush = 1'b1;
    step();
    rob_bus.flush = 1'b0;
    check("flush full empty", rob_bus.empty, 1);
    check("flush full rob_halt", rob_bus.rob_halt, 0);
    check("flush full alloc_tag", rob_bus.alloc_tag, 0);
    check("flush full retired_count", rob_bus.retired_count, 17);

    // 10 outstanding, 4 done but head not done, then flush.
    for (int i = 0; i < 10; i++) alloc(i + 1, i, i + 10, 1, 'h4000 + 4 * i);
    for (int t = 1; t < 5; t++) cmpl(t);
    check("pre-flush retire_valid", rob_bus.retire_valid, 0);
    check("pre-flush alloc_tag", rob_bus.alloc_tag, 10);
    rob_bus.flush      = 1'b1;
    rob_bus.cmpl_valid = 1'b1;
    rob_bus.cmpl_tag   = 4'd0;
    step();
    rob_bus.flush      = 1'b0;
    rob_bus.cmpl_valid = 1'b0;
    check("flush empty", rob_bus.empty, 1);
    check("flush alloc_tag", rob_bus.alloc_tag, 0);
    check("flush retire_valid", rob_bus.retire_valid, 0);
    check("flush rrat_free", rob_bus.rrat_free, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("post-flush%0d retire_valid", i), rob_bus.retire_valid, 0);
      check($sformatf("post-flush%0d rrat_free", i), rob_bus.rrat_free, 0);
    end
    check("post-flush retired_count", rob_bus.retired_count, 17);

    // Asynchronous reset mid-stream.
    alloc(9, 50, 51, 1, 'h6000);
    alloc(10, 52, 53, 1, 'h6004);
    cmpl(0);
    cmpl(1);
    check("pre-reset retire_valid", rob_bus.retire_valid, 1);
    check("pre-reset retired_count", rob_bus.retired_count, 18);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset retire_valid", rob_bus.retire_valid, 0);
    check("async reset rrat_free", rob_bus.rrat_free, 0);
    check("async reset retire_pc", rob_bus.retire_pc, 0);
    check("async reset rrat_free_reg", rob_bus.rrat_free_reg, 0);
    check("async reset retired_count", rob_bus.retired_count, 0);
    check("async reset empty", rob_bus.empty, 1);
    check("async reset alloc_tag", rob_bus.alloc_tag, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("after reset retire_valid", rob_bus.retire_valid, 0);
    check("after reset empty", rob_bus.empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
